// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece control path: motion command encoding,
// board defaults and the motion controller state encoding.
package tetris_pkg;

  typedef enum logic [1:0] {
    MV_RIGHT   = 2'b00,
    MV_LEFT    = 2'b01,
    MV_ROT_CW  = 2'b10,
    MV_ROT_CCW = 2'b11
  } motion_t;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_BOARD_COLS = 10;
  localparam int DEF_BOARD_ROWS = 20;
  localparam int DEF_SPAWN_COL  = 4;

  typedef logic [2:0] pmc_state_t;

  localparam pmc_state_t ST_IDLE      = 3'd0;
  localparam pmc_state_t ST_SPAWN_CHK = 3'd1;
  localparam pmc_state_t ST_READY     = 3'd2;
  localparam pmc_state_t ST_CHECK     = 3'd3;
  localparam pmc_state_t ST_GAME_OVER = 3'd4;

  // Rotation index wraps naturally in two bits.
  function automatic logic [1:0] rot_step(input logic [1:0] rot, input logic ccw);
    return ccw ? (rot - 2'd1) : (rot + 2'd1);
  endfunction

endpackage

// File: rtl/motion_fifo.sv
// Small synchronous FIFO holding pending motion commands; flush empties it in one cycle.
module motion_fifo
  import tetris_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic    Clock,
  input  logic    Reset,
  input  logic    push,
  input  motion_t push_data,
  input  logic    pop,
  input  logic    flush,
  output motion_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  motion_t        mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;
  logic [AW:0]    ptr_one;

  assign ptr_one  = {{AW{1'b0}}, 1'b1};
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clock) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_one;
      if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/piece_motion_ctrl.sv
// Active-piece motion controller: buffers motion commands, services gravity,
// and validates every candidate position with the board collision checker.
module piece_motion_ctrl
  import tetris_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int BOARD_COLS = DEF_BOARD_COLS,
  parameter int BOARD_ROWS = DEF_BOARD_ROWS,
  parameter int SPAWN_COL  = DEF_SPAWN_COL
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] motion,
  input  logic       motion_enable,
  input  logic       gravity_tick,
  input  logic       spawn,
  output logic       chk_req,
  output logic [3:0] chk_col,
  output logic [4:0] chk_row,
  output logic [1:0] chk_rot,
  input  logic       chk_ack,
  input  logic       chk_blocked,
  output logic [3:0] piece_col,
  output logic [4:0] piece_row,
  output logic [1:0] piece_rot,
  output logic       piece_active,
  output logic       lock_pulse,
  output logic       game_over,
  output logic       cmd_dropped
);

  localparam logic [3:0] LAST_COL  = 4'(BOARD_COLS - 1);
  localparam logic [4:0] LAST_ROW  = 5'(BOARD_ROWS - 1);
  localparam logic [3:0] SPAWN_C   = 4'(SPAWN_COL);

  pmc_state_t state;
  logic       grav_pend;
  logic       cand_grav;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;
  motion_t    fifo_dout;
  motion_t    motion_cmd;
  logic       lock_now;
  logic       grav_svc;
  logic       drop_now;

  assign motion_cmd = motion_t'(motion);

  motion_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (motion_cmd),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign chk_req = (state == ST_SPAWN_CHK) || (state == ST_CHECK);

  // Gravity outranks queued motion; a landing either comes straight from the
  // bottom row or from a blocked gravity check.
  always_comb begin
    fifo_pop = 1'b0;
    grav_svc = 1'b0;
    lock_now = 1'b0;
    if (state == ST_READY) begin
      if (grav_pend) begin
        grav_svc = 1'b1;
        lock_now = (piece_row == LAST_ROW);
      end else begin
        fifo_pop = !fifo_empty;
      end
    end else if ((state == ST_CHECK) && chk_ack && chk_blocked && cand_grav) begin
      lock_now = 1'b1;
    end
  end

  assign fifo_flush = lock_now;
  assign fifo_push  = motion_enable && piece_active && !lock_now && (!fifo_full || fifo_pop);
  assign drop_now   = motion_enable && !fifo_push;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      grav_pend    <= 1'b0;
      cand_grav    <= 1'b0;
      chk_col      <= '0;
      chk_row      <= '0;
      chk_rot      <= '0;
      piece_col    <= '0;
      piece_row    <= '0;
      piece_rot    <= '0;
      piece_active <= 1'b0;
      lock_pulse   <= 1'b0;
      game_over    <= 1'b0;
      cmd_dropped  <= 1'b0;
    end else begin
      lock_pulse  <= lock_now;
      cmd_dropped <= drop_now;
      if (lock_now) piece_active <= 1'b0;

      if (lock_now)                          grav_pend <= 1'b0;
      else if (gravity_tick && piece_active) grav_pend <= 1'b1;
      else if (grav_svc)                     grav_pend <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (spawn) begin
            chk_col   <= SPAWN_C;
            chk_row   <= '0;
            chk_rot   <= '0;
            cand_grav <= 1'b0;
            state     <= ST_SPAWN_CHK;
          end
        end
        ST_SPAWN_CHK: begin
          if (chk_ack) begin
            if (chk_blocked) begin
              game_over <= 1'b1;
              state     <= ST_GAME_OVER;
            end else begin
              piece_col    <= chk_col;
              piece_row    <= chk_row;
              piece_rot    <= chk_rot;
              piece_active <= 1'b1;
              state        <= ST_READY;
            end
          end
        end
        ST_READY: begin
          if (grav_svc) begin
            if (lock_now) begin
              state <= ST_IDLE;
            end else begin
              chk_col   <= piece_col;
              chk_row   <= piece_row + 5'd1;
              chk_rot   <= piece_rot;
              cand_grav <= 1'b1;
              state     <= ST_CHECK;
            end
          end else if (fifo_pop) begin
            cand_grav <= 1'b0;
            chk_col   <= piece_col;
            chk_row   <= piece_row;
            chk_rot   <= piece_rot;
            // Wall moves are rejected locally; the entry is still consumed.
            case (fifo_dout)
              MV_RIGHT: begin
                if (piece_col != LAST_COL) begin
                  chk_col <= piece_col + 4'd1;
                  state   <= ST_CHECK;
                end
              end
              MV_LEFT: begin
                if (piece_col != 4'd0) begin
                  chk_col <= piece_col - 4'd1;
                  state   <= ST_CHECK;
                end
              end
              MV_ROT_CW: begin
                chk_rot <= rot_step(piece_rot, 1'b0);
                state   <= ST_CHECK;
              end
              default: begin
                chk_rot <= rot_step(piece_rot, 1'b1);
                state   <= ST_CHECK;
              end
            endcase
          end
        end
        ST_CHECK: begin
          if (chk_ack) begin
            if (!chk_blocked) begin
              piece_col <= chk_col;
              piece_row <= chk_row;
              piece_rot <= chk_rot;
              state     <= ST_READY;
            end else if (cand_grav) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_READY;
            end
          end
        end
        ST_GAME_OVER: state <= ST_GAME_OVER;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Bench for piece_motion_ctrl: a checker responder logs every handshake and a
// position-level model predicts candidates, committed position, locks and drops.
module tb_piece_motion_ctrl;
  import tetris_pkg::*;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int SPAWN   = 4;
  localparam int K_SPAWN = 0;
  localparam int K_GRAV  = 1;
  localparam int K_MOVE  = 2;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] motion;
  logic       motion_enable;
  logic       gravity_tick;
  logic       spawn;
  logic       chk_req;
  logic [3:0] chk_col;
  logic [4:0] chk_row;
  logic [1:0] chk_rot;
  logic       chk_ack;
  logic       chk_blocked;
  logic [3:0] piece_col;
  logic [4:0] piece_row;
  logic [1:0] piece_rot;
  logic       piece_active;
  logic       lock_pulse;
  logic       game_over;
  logic       cmd_dropped;

  typedef struct packed {logic vld; logic [3:0] col; logic [4:0] row; logic [1:0] rot;} cand_t;
  typedef struct packed {logic [3:0] col; logic [4:0] row; logic [1:0] rot; logic blk;} hs_t;

  hs_t   hs_log [256];
  int    hs_wr;
  int    hs_rd;
  int    lock_cnt;
  int    drop_cnt;
  bit    resp_en;
  int    fix_delay;
  int    blk_mode;

  int    m_col, m_row, m_rot;
  bit    m_active, m_over;
  int    exp_locks, exp_drops;
  cand_t exp_q[$];
  cand_t got_q[$];

  int    checks;
  int    passes;

  piece_motion_ctrl dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .motion        (motion),
    .motion_enable (motion_enable),
    .gravity_tick  (gravity_tick),
    .spawn         (spawn),
    .chk_req       (chk_req),
    .chk_col       (chk_col),
    .chk_row       (chk_row),
    .chk_rot       (chk_rot),
    .chk_ack       (chk_ack),
    .chk_blocked   (chk_blocked),
    .piece_col     (piece_col),
    .piece_row     (piece_row),
    .piece_rot     (piece_rot),
    .piece_active  (piece_active),
    .lock_pulse    (lock_pulse),
    .game_over     (game_over),
    .cmd_dropped   (cmd_dropped)
  );

  always #5 Clock = ~Clock;

  // Collision checker stand-in: acks after a delay and records each candidate.
  initial begin : responder
    int  wait_cnt;
    int  cur_delay;
    logic b;
    chk_ack = 1'b0; chk_blocked = 1'b0; hs_wr = 0; wait_cnt = 0; cur_delay = 0;
    forever begin
      @(negedge Clock);
      chk_ack = 1'b0; chk_blocked = 1'b0;
      if (chk_req === 1'b1 && resp_en) begin
        if (wait_cnt == 0) cur_delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 2));
        if (wait_cnt >= cur_delay) begin
          b = (blk_mode == 1) || (blk_mode == 2 && $urandom_range(0, 2) == 0);
          chk_ack = 1'b1; chk_blocked = b;
          hs_log[hs_wr % 256] = '{col: chk_col, row: chk_row, rot: chk_rot, blk: b};
          hs_wr++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (chk_req !== 1'b1) begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : pulse_monitor
    lock_cnt = 0; drop_cnt = 0;
    forever begin
      @(negedge Clock);
      if (lock_pulse === 1'b1)  lock_cnt++;
      if (cmd_dropped === 1'b1) drop_cnt++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_rot = 0; m_active = 0; m_over = 0;
    exp_q.delete(); got_q.delete();
    hs_rd = hs_wr;
  endtask

  task automatic do_reset();
    Reset = 1'b1; motion_enable = 1'b0; gravity_tick = 1'b0; spawn = 1'b0;
    tick(2);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_op(input int kind, input motion_t mv);
    case (kind)
      K_SPAWN: spawn = 1'b1;
      K_GRAV:  gravity_tick = 1'b1;
      default: begin motion = mv; motion_enable = 1'b1; end
    endcase
    tick(1);
    spawn = 1'b0; gravity_tick = 1'b0; motion_enable = 1'b0;
  endtask

  // Position-level rules: what one accepted operation should ask the checker
  // and how the outcome it received moves the piece.
  task automatic model_op(input int kind, input motion_t mv);
    cand_t e, g;
    bit need, blk, lock;
    e = '{vld: 1'b1, col: 4'(m_col), row: 5'(m_row), rot: 2'(m_rot)};
    need = 0; blk = 0; lock = 0;
    case (kind)
      K_SPAWN: if (!m_active && !m_over) begin
        need = 1; e.col = 4'(SPAWN); e.row = '0; e.rot = '0;
      end
      K_GRAV: if (m_active) begin
        if (m_row == ROWS - 1) lock = 1;
        else begin need = 1; e.row = 5'(m_row + 1); end
      end
      default: begin
        if (!m_active) exp_drops++;
        else case (mv)
          MV_RIGHT:  if (m_col < COLS - 1) begin need = 1; e.col = 4'(m_col + 1); end
          MV_LEFT:   if (m_col > 0) begin need = 1; e.col = 4'(m_col - 1); end
          MV_ROT_CW: begin need = 1; e.rot = 2'((m_rot + 1) % 4); end
          default:   begin need = 1; e.rot = 2'((m_rot + 3) % 4); end
        endcase
      end
    endcase
    if (need) begin
      g = '0;
      if (hs_rd != hs_wr) begin
        g = '{vld: 1'b1, col: hs_log[hs_rd % 256].col, row: hs_log[hs_rd % 256].row,
              rot: hs_log[hs_rd % 256].rot};
        blk = hs_log[hs_rd % 256].blk;
        hs_rd++;
      end
      exp_q.push_back(e);
      got_q.push_back(g);
      if (!blk) begin
        m_col = e.col; m_row = e.row; m_rot = e.rot;
        if (kind == K_SPAWN) m_active = 1;
      end else if (kind == K_SPAWN) begin
        m_over = 1;
      end else if (kind == K_GRAV) begin
        lock = 1;
      end
    end
    if (lock) begin
      m_active = 0;
      exp_locks++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({chk_req, chk_col, chk_row, chk_rot, piece_col, piece_row, piece_rot,
         piece_active, lock_pulse, game_over, cmd_dropped} !== '0)
      $display("FAIL reset_outputs got req=%b cand=%h/%h/%h pos=%h/%h/%h act=%b lock=%b go=%b drop=%b want all 0",
               chk_req, chk_col, chk_row, chk_rot, piece_col, piece_row, piece_rot,
               piece_active, lock_pulse, game_over, cmd_dropped);
    else passes++;
  endtask

  task automatic test_spawn();
    int lb;
    lb = lock_cnt;
    fix_delay = 2; blk_mode = 0; resp_en = 1;
    drive_op(K_SPAWN, MV_RIGHT);
    tick(12);
    model_op(K_SPAWN, MV_RIGHT);
    while (exp_q.size() > 0) begin
      cand_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL spawn_cand got %h want %h", g, e);
      else passes++;
    end
    checks++;
    if ({piece_active, piece_col, piece_row, piece_rot} !== {1'b1, 4'd4, 5'd0, 2'd0})
      $display("FAIL spawn_pos got act=%b col=%0d row=%0d rot=%0d want act=1 col=4 row=0 rot=0",
               piece_active, piece_col, piece_row, piece_rot);
    else passes++;
    checks++;
    if (lock_cnt - lb != 0) $display("FAIL spawn_no_lock got %0d lock pulses want 0", lock_cnt - lb);
    else passes++;
  endtask

  task automatic test_move_right();
    int hb;
    hb = hs_wr;
    fix_delay = -1;
    motion = MV_RIGHT; motion_enable = 1'b1;
    tick(3);
    motion_enable = 1'b0;
    tick(30);
    repeat (3) model_op(K_MOVE, MV_RIGHT);
    while (exp_q.size() > 0) begin
      cand_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL right_cand got %h want %h", g, e);
      else passes++;
    end
    checks++;
    if (hs_wr - hb != 3) $display("FAIL right_handshakes got %0d want 3", hs_wr - hb);
    else passes++;
    checks++;
    if (piece_col !== 4'd7) $display("FAIL right_col got %0d want 7", piece_col);
    else passes++;
  endtask

  task automatic test_left_edge();
    int hb;
    while (m_col > 0) begin
      drive_op(K_MOVE, MV_LEFT); tick(12); model_op(K_MOVE, MV_LEFT);
    end
    exp_q.delete(); got_q.delete();
    hb = hs_wr;
    drive_op(K_MOVE, MV_LEFT); tick(12); model_op(K_MOVE, MV_LEFT);
    checks++;
    if (hs_wr - hb != 0) $display("FAIL left_edge_noreq got %0d handshakes want 0", hs_wr - hb);
    else passes++;
    checks++;
    if (piece_col !== 4'd0) $display("FAIL left_edge_col got %0d want 0", piece_col);
    else passes++;
    hb = hs_wr;
    drive_op(K_MOVE, MV_RIGHT); tick(12); model_op(K_MOVE, MV_RIGHT);
    exp_q.delete(); got_q.delete();
    checks++;
    if (hs_wr - hb != 1 || piece_col !== 4'd1)
      $display("FAIL left_edge_after got hs=%0d col=%0d want hs=1 col=1", hs_wr - hb, piece_col);
    else passes++;
  endtask

  task automatic test_rotate();
    while (m_rot != 3) begin
      drive_op(K_MOVE, MV_ROT_CW); tick(12); model_op(K_MOVE, MV_ROT_CW);
    end
    checks++;
    if (piece_rot !== 2'd3) $display("FAIL rot_pre got %0d want 3", piece_rot);
    else passes++;
    drive_op(K_MOVE, MV_ROT_CW); tick(12); model_op(K_MOVE, MV_ROT_CW);
    exp_q.delete(); got_q.delete();
    checks++;
    if (piece_rot !== 2'd0) $display("FAIL rot_wrap got %0d want 0", piece_rot);
    else passes++;
  endtask

  task automatic test_fifo_full();
    motion_t cmds [6];
    int db, hb;
    cmds = '{MV_ROT_CW, MV_ROT_CW, MV_ROT_CCW, MV_RIGHT, MV_LEFT, MV_LEFT};
    resp_en = 0; blk_mode = 0;
    hb = hs_wr;
    drive_op(K_GRAV, MV_RIGHT);
    tick(3);
    checks++;
    if (chk_req !== 1'b1) $display("FAIL fifo_stall_req got %b want 1", chk_req);
    else passes++;
    db = drop_cnt;
    for (int i = 0; i < 6; i++) begin
      motion = cmds[i]; motion_enable = 1'b1;
      tick(1);
    end
    motion_enable = 1'b0;
    tick(2);
    checks++;
    if (drop_cnt - db != 2) $display("FAIL fifo_drops got %0d want 2", drop_cnt - db);
    else passes++;
    resp_en = 1;
    tick(40);
    model_op(K_GRAV, MV_RIGHT);
    for (int i = 0; i < 4; i++) model_op(K_MOVE, cmds[i]);
    while (exp_q.size() > 0) begin
      cand_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL fifo_cand got %h want %h", g, e);
      else passes++;
    end
    checks++;
    if (hs_wr - hb != 5) $display("FAIL fifo_handshakes got %0d want 5", hs_wr - hb);
    else passes++;
  endtask

  task automatic test_lock();
    int lb, db, hb;
    while (m_row < 5) begin
      drive_op(K_GRAV, MV_RIGHT); tick(12); model_op(K_GRAV, MV_RIGHT);
    end
    exp_q.delete(); got_q.delete();
    lb = lock_cnt; hb = hs_wr;
    resp_en = 0;
    drive_op(K_GRAV, MV_RIGHT);
    tick(3);
    drive_op(K_MOVE, MV_RIGHT);
    drive_op(K_MOVE, MV_LEFT);
    drive_op(K_GRAV, MV_RIGHT);
    blk_mode = 1; resp_en = 1;
    tick(15);
    model_op(K_GRAV, MV_RIGHT);
    exp_q.delete(); got_q.delete();
    checks++;
    if (lock_cnt - lb != 1) $display("FAIL lock_pulse_count got %0d want 1", lock_cnt - lb);
    else passes++;
    checks++;
    if (piece_active !== 1'b0 || piece_row !== 5'd5)
      $display("FAIL lock_state got act=%b row=%0d want act=0 row=5", piece_active, piece_row);
    else passes++;
    checks++;
    if (hs_wr - hb != 1) $display("FAIL lock_flush got %0d handshakes want 1", hs_wr - hb);
    else passes++;
    db = drop_cnt;
    drive_op(K_MOVE, MV_ROT_CW); tick(4); model_op(K_MOVE, MV_ROT_CW);
    checks++;
    if (drop_cnt - db != 1) $display("FAIL idle_drop got %0d want 1", drop_cnt - db);
    else passes++;
    blk_mode = 0; hb = hs_wr;
    drive_op(K_SPAWN, MV_RIGHT); tick(20); model_op(K_SPAWN, MV_RIGHT);
    while (exp_q.size() > 0) begin
      cand_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL respawn_cand got %h want %h", g, e);
      else passes++;
    end
    checks++;
    if (hs_wr - hb != 1 || piece_row !== 5'd0 || piece_active !== 1'b1)
      $display("FAIL respawn_clean got hs=%0d row=%0d act=%b want hs=1 row=0 act=1",
               hs_wr - hb, piece_row, piece_active);
    else passes++;
  endtask

  task automatic test_bottom_lock();
    int lb, hb;
    while (m_row < ROWS - 1) begin
      drive_op(K_GRAV, MV_RIGHT); tick(12); model_op(K_GRAV, MV_RIGHT);
    end
    exp_q.delete(); got_q.delete();
    lb = lock_cnt; hb = hs_wr;
    drive_op(K_GRAV, MV_RIGHT); tick(12); model_op(K_GRAV, MV_RIGHT);
    checks++;
    if (hs_wr - hb != 0 || lock_cnt - lb != 1 || piece_active !== 1'b0 || piece_row !== 5'd19)
      $display("FAIL bottom_lock got hs=%0d locks=%0d act=%b row=%0d want hs=0 locks=1 act=0 row=19",
               hs_wr - hb, lock_cnt - lb, piece_active, piece_row);
    else passes++;
  endtask

  task automatic test_game_over();
    int hb;
    blk_mode = 1;
    drive_op(K_SPAWN, MV_RIGHT); tick(12); model_op(K_SPAWN, MV_RIGHT);
    exp_q.delete(); got_q.delete();
    checks++;
    if (game_over !== 1'b1 || piece_active !== 1'b0)
      $display("FAIL game_over_set got go=%b act=%b want go=1 act=0", game_over, piece_active);
    else passes++;
    blk_mode = 0; hb = hs_wr;
    drive_op(K_SPAWN, MV_RIGHT); tick(12); model_op(K_SPAWN, MV_RIGHT);
    checks++;
    if (hs_wr - hb != 0 || game_over !== 1'b1)
      $display("FAIL game_over_sticky got hs=%0d go=%b want hs=0 go=1", hs_wr - hb, game_over);
    else passes++;
    do_reset();
    checks++;
    if (game_over !== 1'b0) $display("FAIL game_over_reset got %b want 0", game_over);
    else passes++;
  endtask

  task automatic test_reset_mid();
    resp_en = 0;
    drive_op(K_SPAWN, MV_RIGHT);
    tick(3);
    checks++;
    if (chk_req !== 1'b1) $display("FAIL reset_mid_pre got req=%b want 1", chk_req);
    else passes++;
    Reset = 1'b1;
    tick(1);
    checks++;
    if ({chk_req, chk_col, chk_row, chk_rot, piece_col, piece_row, piece_rot,
         piece_active, lock_pulse, game_over, cmd_dropped} !== '0)
      $display("FAIL reset_mid got req=%b cand=%h/%h/%h act=%b want all 0",
               chk_req, chk_col, chk_row, chk_rot, piece_active);
    else passes++;
    Reset = 1'b0;
    model_reset();
    resp_en = 1;
  endtask

  task automatic test_random();
    int lb, db, el, ed;
    lb = lock_cnt; db = drop_cnt; el = exp_locks; ed = exp_drops;
    fix_delay = -1;
    for (int i = 0; i < 80; i++) begin
      int kind;
      motion_t mv;
      mv = motion_t'($urandom_range(0, 3));
      if (!m_active && $urandom_range(0, 3) != 0) begin
        kind = K_SPAWN; blk_mode = 0;
      end else begin
        kind = ($urandom_range(0, 9) < 3) ? K_GRAV : K_MOVE; blk_mode = 2;
      end
      drive_op(kind, mv);
      tick(12);
      model_op(kind, mv);
      while (exp_q.size() > 0) begin
        cand_t e, g;
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++;
        if (g !== e) $display("FAIL rand_cand op %0d got %h want %h", i, g, e);
        else passes++;
      end
      checks++;
      if ({piece_active, piece_col, piece_row, piece_rot} !== {m_active, 4'(m_col), 5'(m_row), 2'(m_rot)})
        $display("FAIL rand_pos op %0d got act=%b col=%0d row=%0d rot=%0d want act=%b col=%0d row=%0d rot=%0d",
                 i, piece_active, piece_col, piece_row, piece_rot, m_active, m_col, m_row, m_rot);
      else passes++;
      checks++;
      if (lock_cnt - lb != exp_locks - el || drop_cnt - db != exp_drops - ed || hs_rd != hs_wr)
        $display("FAIL rand_events op %0d got locks=%0d drops=%0d extra_hs=%0d want locks=%0d drops=%0d extra_hs=0",
                 i, lock_cnt - lb, drop_cnt - db, hs_wr - hs_rd, exp_locks - el, exp_drops - ed);
      else passes++;
      hs_rd = hs_wr;
    end
  endtask

  initial begin
    checks = 0; passes = 0; exp_locks = 0; exp_drops = 0; hs_rd = 0;
    Reset = 1'b1; motion = 2'b00; motion_enable = 1'b0; gravity_tick = 1'b0; spawn = 1'b0;
    resp_en = 0; fix_delay = 2; blk_mode = 0;
    test_reset();
    test_spawn();
    test_move_right();
    test_left_edge();
    test_rotate();
    test_fifo_full();
    test_lock();
    test_bottom_lock();
    test_game_over();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
